// File: rtl/burst_mem_responder_if.sv
// Burst memory port between the core's cacheline adaptor (master) and the
// burst memory responder (slave).
//   address_i : request byte address (line-aligned use, low 5 bits ignored)
//   read_i    : read request, held until the final beat
//   write_i   : write request, held until the final beat
//   burst_i   : write data beat, requester -> responder
//   burst_o   : read data beat, responder -> requester
//   resp_o    : beat valid, four consecutive cycles per transaction
//   err_o     : sticky protocol error flag
interface burst_mem_responder_if;
  logic [31:0] address_i;
  logic        read_i;
  logic        write_i;
  logic [63:0] burst_i;
  logic [63:0] burst_o;
  logic        resp_o;
  logic        err_o;

  modport master (
    output address_i, read_i, write_i, burst_i,
    input  burst_o, resp_o, err_o
  );

  modport slave (
    input  address_i, read_i, write_i, burst_i,
    output burst_o, resp_o, err_o
  );
endinterface

// File: rtl/burst_mem_responder.sv
// Cacheline burst memory responder. Accepts one line-aligned read or write,
// waits LATENCY cycles, then streams four 64-bit beats of a 256-bit line
// held in an internal single-port array.
//   clk : clock, rising edge
//   rst : synchronous active-high reset; clears controller state, not memory
//   bus : burst_mem_responder_if.slave (request, data beats, resp, err)
// Optional feature: define BURST_MEM_CHECK_EN to compile in the sticky
// protocol checker driving err_o; otherwise err_o is tied low.
module burst_mem_responder #(
  parameter int DEPTH_LINES = 256,
  parameter int LATENCY     = 4
) (
  input  logic clk,
  input  logic rst,
  burst_mem_responder_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH_LINES);
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] line_q;
  logic             wr_q;
  logic [LAT_W-1:0] lat_q;
  logic [1:0]       beat_q;

  logic [63:0]      mem [DEPTH_LINES*4];
  logic [63:0]      rd_q;

  logic             accept;
  logic             resp;
  logic             rd_en;
  logic             wr_en;
  logic [1:0]       rd_word;

  // Both request lines high is illegal and never accepted.
  assign accept = (state_q == IDLE) && (bus.read_i ^ bus.write_i);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = WAIT;
      WAIT:    if (lat_q == '0) state_d = BURST;
      BURST:   if (beat_q == 2'd3) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / array control logic
  always_comb begin
    resp    = (state_q == BURST);
    // Word k+1 is fetched during beat k (word 0 in the last WAIT cycle) so the
    // registered read lands exactly on its beat.
    rd_word = (state_q == WAIT) ? 2'd0 : beat_q + 2'd1;
    rd_en   = !wr_q && (((state_q == WAIT) && (lat_q == '0)) ||
                        ((state_q == BURST) && (beat_q != 2'd3)));
    // A beat coinciding with rst is not committed.
    wr_en   = wr_q && (state_q == BURST) && !rst;
  end

  // Transaction latches and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
      wr_q   <= 1'b0;
      lat_q  <= '0;
      beat_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          line_q <= bus.address_i[5 +: IDX_W];
          wr_q   <= bus.write_i;
          lat_q  <= LAT_W'(LATENCY - 1);
        end
        WAIT: begin
          beat_q <= '0;
          if (lat_q != '0) lat_q <= lat_q - 1'b1;
        end
        BURST:   beat_q <= beat_q + 2'd1;
        default: ;
      endcase
    end
  end

  // Single-port line array: at most one word access per cycle.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{line_q, beat_q}] <= bus.burst_i;
    if (rd_en) rd_q <= mem[{line_q, rd_word}];
  end

  assign bus.resp_o  = resp;
  assign bus.burst_o = (resp && !wr_q) ? rd_q : 64'd0;

`ifdef BURST_MEM_CHECK_EN
  logic        err_q;
  logic [26:0] tag_q;
  logic        busy;
  logic        req_drop;
  logic        opp_rise;
  logic        addr_chg;

  assign busy     = (state_q == WAIT) || (state_q == BURST);
  assign req_drop = wr_q ? !bus.write_i : !bus.read_i;
  assign opp_rise = wr_q ? bus.read_i : bus.write_i;
  assign addr_chg = bus.address_i[31:5] != tag_q;

  // Observes only; never feeds back into the transaction flow.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
      tag_q <= '0;
    end else begin
      if (accept) tag_q <= bus.address_i[31:5];
      if ((bus.read_i && bus.write_i) ||
          (busy && (req_drop || opp_rise || addr_chg)))
        err_q <= 1'b1;
    end
  end

  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif

  // Offset and aliasing address bits are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^bus.address_i;
endmodule

// File: tb/tb_burst_mem_responder.sv
// Scoreboard bench for burst_mem_responder: one LATENCY=4 instance and one
// LATENCY=1 instance, each on its own interface.
module tb_burst_mem_responder;
  localparam int LAT_A = 4;
  localparam int LAT_B = 1;
`ifdef BURST_MEM_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  burst_mem_responder_if ifa();
  burst_mem_responder_if ifb();

  logic        rd [2];
  logic        wr [2];
  logic [31:0] ad [2];
  logic [63:0] wd [2];

  assign ifa.read_i    = rd[0];
  assign ifa.write_i   = wr[0];
  assign ifa.address_i = ad[0];
  assign ifa.burst_i   = wd[0];
  assign ifb.read_i    = rd[1];
  assign ifb.write_i   = wr[1];
  assign ifb.address_i = ad[1];
  assign ifb.burst_i   = wd[1];

  burst_mem_responder #(.DEPTH_LINES(256), .LATENCY(LAT_A)) u_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  burst_mem_responder #(.DEPTH_LINES(256), .LATENCY(LAT_B)) u_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  int checks = 0;
  int fails  = 0;

  logic [63:0] model [int];
  logic [63:0] exp_q [$];

  logic [63:0] pat_a [4] = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                             64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
  logic [63:0] pat_b [4] = '{64'hA5A5_0000_0000_0001, 64'hA5A5_0000_0000_0002,
                             64'hA5A5_0000_0000_0003, 64'hA5A5_0000_0000_0004};
  logic [63:0] pat_o [4] = '{64'hDEAD_0000_0000_0000, 64'hDEAD_0000_0000_0001,
                             64'hDEAD_0000_0000_0002, 64'hDEAD_0000_0000_0003};
  logic [63:0] pat_n [4] = '{64'hBEEF_0000_0000_0010, 64'hBEEF_0000_0000_0011,
                             64'hBEEF_0000_0000_0012, 64'hBEEF_0000_0000_0013};
  logic [63:0] pat_z [4] = '{64'd0, 64'd0, 64'd0, 64'd0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int key(input int s, input logic [31:0] a, input int k);
    return s * 4096 + int'(a[12:5]) * 4 + k;
  endfunction

  function automatic logic get_resp(input int s);
    return s != 0 ? ifb.resp_o : ifa.resp_o;
  endfunction

  function automatic logic [63:0] get_bout(input int s);
    return s != 0 ? ifb.burst_o : ifa.burst_o;
  endfunction

  function automatic logic get_err(input int s);
    return s != 0 ? ifb.err_o : ifa.err_o;
  endfunction

  // ntx transactions with the request held throughout; request dropped in
  // the DONE cycle of the last one. Inputs change and outputs are sampled
  // on the falling edge.
  task automatic txn(input int s, input bit w, input logic [31:0] a,
                     input logic [63:0] d [4], input int ntx);
    int lat;
    int p;
    int last;
    int ph;
    bit beat;
    logic [63:0] e;
    lat  = (s != 0) ? LAT_B : LAT_A;
    p    = lat + 6;
    last = ntx * p - 2;
    @(negedge clk);
    rd[s] = !w; wr[s] = w; ad[s] = a;
    for (int i = 0; i <= last; i++) begin
      @(negedge clk);
      ph   = i % p;
      beat = (ph >= lat) && (ph < lat + 4);
      if (ph == 0 && !w)
        for (int k = 0; k < 4; k++) exp_q.push_back(model[key(s, a, k)]);
      chk("resp", 64'(get_resp(s)), 64'(beat));
      if (beat && !w) begin
        if (exp_q.size() == 0) begin
          chk("sb_empty", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rdata", get_bout(s), e);
        end
      end else begin
        chk("bout_zero", get_bout(s), 64'd0);
      end
      if (beat && w) begin
        wd[s] = d[ph - lat];
        model[key(s, a, ph - lat)] = d[ph - lat];
      end
      chk("err_legal", 64'(get_err(s)), 64'd0);
    end
    rd[s] = 1'b0; wr[s] = 1'b0; wd[s] = 64'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      rd[s] = 1'b0; wr[s] = 1'b0; ad[s] = 32'd0; wd[s] = 64'd0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      chk("rst_resp", 64'(get_resp(s)), 64'd0);
      chk("rst_bout", get_bout(s), 64'd0);
      chk("rst_err",  64'(get_err(s)), 64'd0);
    end

    // Write-then-read
    txn(0, 1'b1, 32'h0000_0040, pat_a, 1);
    txn(0, 1'b0, 32'h0000_0040, pat_z, 1);

    // Aliasing and offset: 0x2000 and 0x1F share line index 0
    txn(0, 1'b1, 32'h0000_2000, pat_b, 1);
    txn(0, 1'b0, 32'h0000_001F, pat_z, 1);

    // Back-to-back reads with read_i held through DONE and IDLE
    txn(0, 1'b0, 32'h0000_0040, pat_z, 2);

    // Reset in beat 2 of a write to line 3: beats 0-1 commit, 2-3 do not
    txn(0, 1'b1, 32'h0000_0060, pat_o, 1);
    @(negedge clk);
    wr[0] = 1'b1; ad[0] = 32'h0000_0060;
    for (int i = 0; i <= LAT_A + 2; i++) begin
      @(negedge clk);
      if (i >= LAT_A) wd[0] = pat_n[i - LAT_A];
      if (i >= LAT_A && i < LAT_A + 2) model[key(0, 32'h60, i - LAT_A)] = pat_n[i - LAT_A];
    end
    chk("rst_mid_resp_b2", 64'(get_resp(0)), 64'd1);
    rst = 1'b1; wr[0] = 1'b0;
    @(negedge clk);
    chk("rst_mid_resp", 64'(get_resp(0)), 64'd0);
    chk("rst_mid_bout", get_bout(0), 64'd0);
    rst = 1'b0; wd[0] = 64'd0;
    txn(0, 1'b0, 32'h0000_0060, pat_z, 1);

    // LATENCY=1 instance
    txn(1, 1'b1, 32'h0000_0080, pat_a, 1);
    txn(1, 1'b0, 32'h0000_0080, pat_z, 1);

    // Checker: both request lines for one IDLE cycle
    @(negedge clk);
    rd[0] = 1'b1; wr[0] = 1'b1; ad[0] = 32'h0000_0040;
    @(negedge clk);
    rd[0] = 1'b0; wr[0] = 1'b0;
    chk("err_set", 64'(get_err(0)), 64'(EXP_ERR));
    for (int i = 0; i < LAT_A + 6; i++) begin
      @(negedge clk);
      chk("no_txn_resp", 64'(get_resp(0)), 64'd0);
    end
    chk("err_sticky", 64'(get_err(0)), 64'(EXP_ERR));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("err_cleared", 64'(get_err(0)), 64'd0);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
